// File: rtl/a_axi_write_response_merger_4_to_1_if.sv
// a_axi_write_response_merger_4_to_1_if: per-SLR B channels plus the merged host B channel.
// master is the merger's view, slave is the view of the SLR slaves and host together.
interface a_axi_write_response_merger_4_to_1_if;
    logic       s_axi_control_BVALID_slr_0;
    logic       s_axi_control_BVALID_slr_1;
    logic       s_axi_control_BVALID_slr_2;
    logic       s_axi_control_BVALID_slr_3;
    logic       s_axi_control_BREADY_slr_0;
    logic       s_axi_control_BREADY_slr_1;
    logic       s_axi_control_BREADY_slr_2;
    logic       s_axi_control_BREADY_slr_3;
    logic [1:0] s_axi_control_BRESP_slr_0;
    logic [1:0] s_axi_control_BRESP_slr_1;
    logic [1:0] s_axi_control_BRESP_slr_2;
    logic [1:0] s_axi_control_BRESP_slr_3;
    logic       s_axi_control_BVALID;
    logic       s_axi_control_BREADY;
    logic [1:0] s_axi_control_BRESP;

    modport master (
        input  s_axi_control_BVALID_slr_0, s_axi_control_BVALID_slr_1,
               s_axi_control_BVALID_slr_2, s_axi_control_BVALID_slr_3,
               s_axi_control_BRESP_slr_0, s_axi_control_BRESP_slr_1,
               s_axi_control_BRESP_slr_2, s_axi_control_BRESP_slr_3,
               s_axi_control_BREADY,
        output s_axi_control_BREADY_slr_0, s_axi_control_BREADY_slr_1,
               s_axi_control_BREADY_slr_2, s_axi_control_BREADY_slr_3,
               s_axi_control_BVALID, s_axi_control_BRESP
    );

    modport slave (
        output s_axi_control_BVALID_slr_0, s_axi_control_BVALID_slr_1,
               s_axi_control_BVALID_slr_2, s_axi_control_BVALID_slr_3,
               s_axi_control_BRESP_slr_0, s_axi_control_BRESP_slr_1,
               s_axi_control_BRESP_slr_2, s_axi_control_BRESP_slr_3,
               s_axi_control_BREADY,
        input  s_axi_control_BREADY_slr_0, s_axi_control_BREADY_slr_1,
               s_axi_control_BREADY_slr_2, s_axi_control_BREADY_slr_3,
               s_axi_control_BVALID, s_axi_control_BRESP
    );
endinterface

// File: rtl/a_axi_write_response_merger_4_to_1.sv
// a_axi_write_response_merger_4_to_1: merges four skewed per-SLR B responses into one host B response.
// Optional A_AXI_RESP_MISMATCH_CNT_EN adds a saturating count of merges with non-identical head codes.
module a_axi_write_response_merger_4_to_1 #(
    parameter int PENDING_DEPTH      = 4,
    parameter int PENDING_ADDR_WIDTH = 2
) (
    input logic ap_clk,
    input logic ap_rst_n,
    a_axi_write_response_merger_4_to_1_if.master bus
`ifdef A_AXI_RESP_MISMATCH_CNT_EN
    ,
    output logic [15:0] resp_mismatch_cnt
`endif
);
    localparam logic [PENDING_ADDR_WIDTH:0] FULL = PENDING_DEPTH[PENDING_ADDR_WIDTH:0];

    logic       rst_q;
    logic [3:0] bvalid_slr;
    logic [3:0] bready_slr;
    logic [3:0] nonempty;
    logic [1:0] bresp_slr [4];
    logic [1:0] head [4];
    logic       all_avail, out_free, pop;
    logic       any_decerr, any_slverr;
    logic [1:0] merged;
    logic       bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;

    assign bvalid_slr = {bus.s_axi_control_BVALID_slr_3, bus.s_axi_control_BVALID_slr_2,
                         bus.s_axi_control_BVALID_slr_1, bus.s_axi_control_BVALID_slr_0};
    assign bresp_slr[0] = bus.s_axi_control_BRESP_slr_0;
    assign bresp_slr[1] = bus.s_axi_control_BRESP_slr_1;
    assign bresp_slr[2] = bus.s_axi_control_BRESP_slr_2;
    assign bresp_slr[3] = bus.s_axi_control_BRESP_slr_3;
    assign bus.s_axi_control_BREADY_slr_0 = bready_slr[0];
    assign bus.s_axi_control_BREADY_slr_1 = bready_slr[1];
    assign bus.s_axi_control_BREADY_slr_2 = bready_slr[2];
    assign bus.s_axi_control_BREADY_slr_3 = bready_slr[3];
    assign bus.s_axi_control_BVALID = bvalid_q;
    assign bus.s_axi_control_BRESP  = bresp_q;

    // Keeps every SLR stalled for the first clock after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_q <= 1'b1;
        else           rst_q <= 1'b0;
    end

    for (genvar i = 0; i < 4; i++) begin : g_fifo
        logic [1:0]                    mem_q [PENDING_DEPTH];
        logic [1:0]                    mem_d [PENDING_DEPTH];
        logic [PENDING_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [PENDING_ADDR_WIDTH:0]   cnt_q, cnt_d;
        logic                          push;
        assign bready_slr[i] = !rst_q && (cnt_q != FULL);
        assign push          = bvalid_slr[i] && bready_slr[i];
        assign nonempty[i]   = cnt_q != '0;
        assign head[i]       = mem_q[rd_ptr_q];
        always_comb begin
            mem_d = mem_q;
            if (push) mem_d[wr_ptr_q] = bresp_slr[i];
            wr_ptr_d = wr_ptr_q + PENDING_ADDR_WIDTH'(push);
            rd_ptr_d = rd_ptr_q + PENDING_ADDR_WIDTH'(pop);
            cnt_d    = cnt_q + (PENDING_ADDR_WIDTH+1)'(push) - (PENDING_ADDR_WIDTH+1)'(pop);
        end
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                mem_q    <= '{default: '0};
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                mem_q    <= mem_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end
    end

    assign all_avail = &nonempty;
    assign out_free  = !bvalid_q || bus.s_axi_control_BREADY;
    assign pop       = all_avail && out_free;

    // EXOKAY folds into OKAY; DECERR outranks SLVERR.
    always_comb begin
        any_decerr = 1'b0;
        any_slverr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            any_decerr = any_decerr || (head[k] == 2'b11);
            any_slverr = any_slverr || (head[k] == 2'b10);
        end
        merged   = any_decerr ? 2'b11 : any_slverr ? 2'b10 : 2'b00;
        bvalid_d = pop ? 1'b1 : (bvalid_q && bus.s_axi_control_BREADY) ? 1'b0 : bvalid_q;
        bresp_d  = pop ? merged : bresp_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

`ifdef A_AXI_RESP_MISMATCH_CNT_EN
    logic [15:0] mismatch_cnt_q, mismatch_cnt_d;
    logic        mismatch;
    assign mismatch = !((head[0] == head[1]) && (head[1] == head[2]) && (head[2] == head[3]));
    assign mismatch_cnt_d = (pop && mismatch && (mismatch_cnt_q != 16'hFFFF)) ? mismatch_cnt_q + 16'd1 : mismatch_cnt_q;
    assign resp_mismatch_cnt = mismatch_cnt_q;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) mismatch_cnt_q <= '0;
        else           mismatch_cnt_q <= mismatch_cnt_d;
    end
`endif
endmodule

// File: tb/tb_a_axi_write_response_merger_4_to_1.sv
// tb_a_axi_write_response_merger_4_to_1: directed plus random stimulus against a queue-based model.
// Define A_AXI_RESP_MISMATCH_CNT_EN on both files to exercise the mismatch counter.
module tb_a_axi_write_response_merger_4_to_1;
    localparam int DEPTH = 4;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    a_axi_write_response_merger_4_to_1_if bus ();
`ifdef A_AXI_RESP_MISMATCH_CNT_EN
    logic [15:0] resp_mismatch_cnt;
`endif

    a_axi_write_response_merger_4_to_1 #(.PENDING_DEPTH(DEPTH), .PENDING_ADDR_WIDTH(2)) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus(bus.master)
`ifdef A_AXI_RESP_MISMATCH_CNT_EN
        ,
        .resp_mismatch_cnt(resp_mismatch_cnt)
`endif
    );

    logic [1:0] mq [4][$];
    logic       m_rst = 1'b1;
    logic       m_bvalid = 1'b0;
    logic [1:0] m_bresp = 2'b00;
    int         m_cnt = 0;
    int         checks = 0;
    int         fails = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sev(input logic [1:0] c);
        return (c == 2'b11) ? 2 : (c == 2'b10) ? 1 : 0;
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model over the posedge.
    task automatic cyc(input logic [3:0] v, input logic [7:0] r, input logic hr, input logic rn = 1'b1);
        logic [3:0] rdy;
        logic [1:0] h [4];
        int         worst;
        bit         same;
        @(negedge ap_clk);
        ap_rst_n = rn;
        bus.s_axi_control_BVALID_slr_0 = v[0];
        bus.s_axi_control_BVALID_slr_1 = v[1];
        bus.s_axi_control_BVALID_slr_2 = v[2];
        bus.s_axi_control_BVALID_slr_3 = v[3];
        bus.s_axi_control_BRESP_slr_0 = r[1:0];
        bus.s_axi_control_BRESP_slr_1 = r[3:2];
        bus.s_axi_control_BRESP_slr_2 = r[5:4];
        bus.s_axi_control_BRESP_slr_3 = r[7:6];
        bus.s_axi_control_BREADY = hr;
        if (!rn) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_rst = 1'b1;
            m_bvalid = 1'b0;
            m_bresp = 2'b00;
            m_cnt = 0;
        end
        #1;
        for (int i = 0; i < 4; i++) rdy[i] = !m_rst && (mq[i].size() < DEPTH);
        chk("bready_slr", {12'd0, bus.s_axi_control_BREADY_slr_3, bus.s_axi_control_BREADY_slr_2,
                           bus.s_axi_control_BREADY_slr_1, bus.s_axi_control_BREADY_slr_0}, {12'd0, rdy});
        chk("bvalid", {15'd0, bus.s_axi_control_BVALID}, {15'd0, m_bvalid});
        chk("bresp", {14'd0, bus.s_axi_control_BRESP}, {14'd0, m_bresp});
`ifdef A_AXI_RESP_MISMATCH_CNT_EN
        chk("mismatch_cnt", resp_mismatch_cnt, m_cnt[15:0]);
`endif
        if (mq[0].size() > 0 && mq[1].size() > 0 && mq[2].size() > 0 && mq[3].size() > 0 && (!m_bvalid || hr)) begin
            worst = 0;
            same = 1'b1;
            for (int i = 0; i < 4; i++) begin
                h[i] = mq[i].pop_front();
                if (sev(h[i]) > worst) worst = sev(h[i]);
                if (h[i] != h[0]) same = 1'b0;
            end
            m_bvalid = 1'b1;
            m_bresp = (worst == 2) ? 2'b11 : (worst == 1) ? 2'b10 : 2'b00;
            if (!same && m_cnt < 65535) m_cnt++;
        end else if (m_bvalid && hr) m_bvalid = 1'b0;
        for (int i = 0; i < 4; i++) if (v[i] && rdy[i]) mq[i].push_back(r[2*i +: 2]);
        m_rst = !rn;
    endtask

    initial begin
        bus.s_axi_control_BVALID_slr_0 = 1'b0;
        bus.s_axi_control_BVALID_slr_1 = 1'b0;
        bus.s_axi_control_BVALID_slr_2 = 1'b0;
        bus.s_axi_control_BVALID_slr_3 = 1'b0;
        bus.s_axi_control_BRESP_slr_0 = 2'b00;
        bus.s_axi_control_BRESP_slr_1 = 2'b00;
        bus.s_axi_control_BRESP_slr_2 = 2'b00;
        bus.s_axi_control_BRESP_slr_3 = 2'b00;
        bus.s_axi_control_BREADY = 1'b1;
        repeat (3) cyc(4'h0, 8'h00, 1'b1, 1'b0);
        repeat (3) cyc(4'h0, 8'h00, 1'b1);
        // aligned OKAY
        cyc(4'hF, 8'h00, 1'b1);
        repeat (4) cyc(4'h0, 8'h00, 1'b1);
        // skew with one SLVERR arriving late
        cyc(4'h1, 8'h00, 1'b1);
        cyc(4'h2, 8'h00, 1'b1);
        cyc(4'h4, 8'h00, 1'b1);
        repeat (12) cyc(4'h0, 8'h00, 1'b1);
        cyc(4'h8, 8'b10_00_00_00, 1'b1);
        repeat (4) cyc(4'h0, 8'h00, 1'b1);
        // depth limit on SLR0
        repeat (6) cyc(4'h1, 8'h00, 1'b1);
        cyc(4'hE, 8'h00, 1'b1);
        repeat (3) cyc(4'hF, 8'h00, 1'b1);
        repeat (3) cyc(4'hE, 8'h00, 1'b1);
        repeat (5) cyc(4'h0, 8'h00, 1'b1);
        // host backpressure with DECERR in the second set
        cyc(4'hF, 8'h00, 1'b0);
        cyc(4'hF, 8'b00_11_00_00, 1'b0);
        cyc(4'hF, 8'h00, 1'b0);
        repeat (5) cyc(4'h0, 8'h00, 1'b0);
        repeat (5) cyc(4'h0, 8'h00, 1'b1);
        // reset while SLR1 holds entries and BVALID is high
        cyc(4'hF, 8'h00, 1'b0);
        cyc(4'h2, 8'h00, 1'b0);
        cyc(4'h2, 8'h00, 1'b0);
        repeat (2) cyc(4'h0, 8'h00, 1'b0);
        repeat (2) cyc(4'h0, 8'h00, 1'b1, 1'b0);
        cyc(4'h0, 8'h00, 1'b1);
        cyc(4'hF, 8'h00, 1'b1);
        repeat (4) cyc(4'h0, 8'h00, 1'b1);
        // random traffic with occasional reset
        repeat (600) cyc(4'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 127) != 0);
        repeat (8) cyc(4'h0, 8'h00, 1'b1);
`ifdef A_AXI_RESP_MISMATCH_CNT_EN
        repeat (2) cyc(4'h0, 8'h00, 1'b1, 1'b0);
        cyc(4'hF, 8'h00, 1'b1);
        cyc(4'hF, 8'b00_00_01_00, 1'b1);
        cyc(4'hF, 8'b00_00_00_10, 1'b1);
        repeat (4) cyc(4'h0, 8'h00, 1'b1);
        repeat (65540) cyc(4'hF, 8'b00_00_01_00, 1'b1);
        repeat (4) cyc(4'h0, 8'h00, 1'b1);
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/a_axi_write_response_merger_4_to_1.md
Name: a_axi_write_response_merger_4_to_1

Overview:
- Return-path companion to the 1-to-4 AXI-Lite control write broadcast.
- Each host write reaches all four SLR copies of the control slave, so each SLR returns one B response per write.
- This block collects the four per-SLR B responses, which arrive skewed because of the inter-SLR pipelining, and issues exactly one merged B response to the host per write.
- Sits between the four SLR-local control slaves and the host-facing s_axi_control B channel.

Parameters:
- PENDING_DEPTH, 4, per-SLR response FIFO depth; power of two, minimum 2.
- PENDING_ADDR_WIDTH, 2, log2(PENDING_DEPTH).

Ports:
- ap_clk  in  1  single clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- s_axi_control_BVALID_slr_0..3  in  1  per-SLR response valid.
- s_axi_control_BREADY_slr_0..3  out  1  per-SLR response ready.
- s_axi_control_BRESP_slr_0..3  in  2  per-SLR response code.
- s_axi_control_BVALID  out  1  merged response valid to host.
- s_axi_control_BREADY  in  1  host ready.
- s_axi_control_BRESP  out  2  merged response code.

Behaviour:
- Reset (async assert, sync release):
  - All four FIFOs empty, BVALID=0, BRESP=2'b00.
  - Registered flag rst_q=1 while ap_rst_n low; it clears on the first ap_clk edge with ap_rst_n high.
  - BREADY_slr_i=0 while rst_q=1.
- Per-SLR FIFO i:
  - Holds 2-bit BRESP values; count ranges 0..PENDING_DEPTH.
  - BREADY_slr_i = !rst_q && (count_i != PENDING_DEPTH). Combinational from registers only; no dependence on BVALID_slr_i.
  - Push on BVALID_slr_i && BREADY_slr_i.
  - Pointers wrap modulo PENDING_DEPTH.
  - Simultaneous push and pop leaves the count unchanged. No push while full; no bypass of a full FIFO by a same-cycle pop.
- Merge condition:
  - all_avail = all four FIFOs non-empty.
  - out_free = !BVALID || BREADY.
  - When all_avail && out_free: pop all four heads in the same cycle and register BVALID=1 and BRESP=merge(heads).
  - Otherwise, if BVALID && BREADY: BVALID=0.
  - BRESP holds its value while BVALID=1 and BREADY=0. BVALID never drops without a handshake.
- Merge rule, on the four head codes:
  - Any 2'b11 (DECERR) gives 2'b11.
  - Otherwise any 2'b10 (SLVERR) gives 2'b10.
  - Otherwise 2'b00. EXOKAY (2'b01) is treated as OKAY.
- Latency:
  - The last of the four per-SLR handshakes happens in cycle N.
  - BVALID is high from cycle N+2 when the output register is free.
  - Back-to-back throughput is one merged response per cycle when all FIFOs hold data and BREADY=1.
- Ordering: FIFO order is preserved. The k-th merged response combines the k-th response from each SLR.
- Skew: any SLR may run up to PENDING_DEPTH responses ahead of the slowest. Beyond that, its BREADY drops until a merge pops.
- Reset mid-operation: all pending entries are discarded and an in-flight BVALID drops immediately. No partial merge survives.

Optional Feature:
- Macro: A_AXI_RESP_MISMATCH_CNT_EN.
- With the macro defined:
  - Extra output port resp_mismatch_cnt, out, 16 bits.
  - It increments on each merge whose four head codes are not all identical, with 01 and 00 considered distinct.
  - It saturates at 16'hFFFF and resets to 0.
- Without the macro: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Aligned OKAY: all four SLRs present BRESP=00 in cycle 10 with BREADY=1 held -> BVALID=1 in cycle 12 with BRESP=00; one pulse only.
- Skew plus error: SLR0..2 send 00 in cycles 5,6,7 and SLR3 sends 10 in cycle 20 -> nothing before cycle 22; BVALID in cycle 22 with BRESP=10.
- Depth limit: SLR0 offers 5 responses of 00 back-to-back while SLR1..3 stay idle -> BREADY_slr_0 drops after 4 accepted. The 5th is accepted only after one merge completes.
- Host backpressure: 3 writes' responses all arrive while BREADY=0 -> BVALID=1 with the first merged code held stable. Releasing BREADY gives 3 consecutive BVALID cycles with codes in order, e.g. 00, 11, 00 when the second set contains one 11.
- Reset mid-flight: 2 entries are pending in SLR1 and BVALID=1 when ap_rst_n pulses low -> BVALID=0 at once, all BREADY_slr_i=0 during reset. After release, a fresh aligned set produces exactly one merged response.
- Mismatch counter (macro on): merges with head sets {00,00,00,00}, {00,01,00,00}, {10,00,00,00} -> resp_mismatch_cnt=2. With the counter preloaded near saturation via 65535+ mismatching merges, it stays at 16'hFFFF.
